// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package instr_loader_pkg;

    typedef enum logic [1:0] {
        HDR,
        DATA,
        DONE,
        ERR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_word_packer.sv
// Packs an 8-bit stream big-endian into 32-bit words; word_valid_o pulses
// in the same cycle the last byte of a word is accepted.
module byte_word_packer
    import instr_loader_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          byte_valid_i,
    input  logic [7:0]                    byte_i,
    output logic                          word_valid_o,
    output logic [BYTES_PER_WORD*8-1:0]   word_o
);

    localparam int SHIFT_W = (BYTES_PER_WORD - 1) * 8;

    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;

    // The final byte completes the word directly, so only the leading bytes are stored.
    assign word_valid_o = byte_valid_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign word_o       = {shift_q, byte_i};

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid_i) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = {shift_q[SHIFT_W-9:0], byte_i};
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: header word count, then N big-endian words written to
// consecutive instruction-memory addresses while the core is held in reset.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    MAX_WORDS   = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   in_valid_i,
    input  logic [7:0]             in_data_i,
    output logic                   in_ready_o,
    output logic                   mem_write_en_o,
    output logic [ADDR_WIDTH-1:0]  mem_write_addr_o,
    output logic [INSTR_WIDTH-1:0] mem_write_data_o,
    output logic                   cpu_hold_o,
    output logic                   load_done_o,
    output logic                   load_error_o
);

    localparam int WCNT_W = $clog2(MAX_WORDS + 1);

    loader_state_t          state_q, state_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d, wcnt_inc;
    logic [31:0]            hdr_q, hdr_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] data_q, data_d;
    logic                   hold_q, hold_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   reload;
    logic                   word_valid;
    logic [31:0]            word;

    // Ready is a pure state decode: no combinational path from in_valid_i.
    assign in_ready_o = (state_q == HDR) || (state_q == DATA);
    assign accept     = in_valid_i && in_ready_o;
    assign reload     = start_i && ((state_q == DONE) || (state_q == ERR));
    assign wcnt_inc   = wcnt_q + 1'b1;

    byte_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (reload),
        .byte_valid_i (accept),
        .byte_i       (in_data_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        hdr_d   = hdr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            HDR: begin
                if (word_valid) begin
                    hdr_d  = word;
                    wcnt_d = '0;
                    if (word == '0)                   state_d = DONE;
                    else if (word > 32'(MAX_WORDS))   state_d = ERR;
                    else                              state_d = DATA;
                end
            end
            DATA: begin
                if (word_valid) begin
                    we_d   = 1'b1;
                    addr_d = BASE_ADDR + (ADDR_WIDTH'(wcnt_q) << 2);
                    data_d = INSTR_WIDTH'(word);
                    wcnt_d = wcnt_inc;
                    if (32'(wcnt_inc) == hdr_q) state_d = DONE;
                end
            end
            DONE, ERR: begin
                if (start_i) begin
                    state_d = HDR;
                    wcnt_d  = '0;
                end
            end
            default: state_d = HDR;
        endcase
    end

    // The hold drops one cycle after DONE is entered, so the last write lands first.
    assign hold_d = !((state_q == DONE) && (state_d == DONE));
    assign done_d = (state_d == DONE);
    assign err_d  = (state_d == ERR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HDR;
            wcnt_q  <= '0;
            hdr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            hdr_q   <= hdr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_write_en_o   = we_q;
    assign mem_write_addr_o = addr_q;
    assign mem_write_data_o = data_q;
    assign cpu_hold_o       = hold_q;
    assign load_done_o      = done_q;
    assign load_error_o     = err_q;

endmodule
